prog_byte_loader: RTL

//  Upstream feeder for the RAM programmer: deserializes program bytes from a 3-wire serial

---
 rtl/prog_byte_loader_pkg.sv | 21 ++
 rtl/prog_byte_loader_byte_fifo.sv | 54 +++++
 rtl/prog_byte_loader.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/prog_byte_loader_pkg.sv
// Constants and state encodings shared by the byte loader, the RAM programmer and the RAM.
package prog_byte_loader_pkg;

    localparam int MEM_DEPTH = 16;
    localparam int SER_BITS  = 8;

    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_OFF   = ST_OFF,
        S_IDLE  = ST_IDLE,
        S_PULSE = ST_PULSE,
        S_GAP   = ST_GAP,
        S_DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/prog_byte_loader_byte_fifo.sv
// Small byte FIFO with synchronous reset and flush; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_pop;
    logic          do_push;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/prog_byte_loader.sv
// Serial-to-byte feeder for the RAM programmer: deserializes pin bytes into a FIFO and
// replays them as paced byte_out/new_byte pulses during a programming session.
module prog_byte_loader #(
    parameter int FIFO_DEPTH   = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 8,
    parameter int MEM_DEPTH    = prog_byte_loader_pkg::MEM_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ser_clk,
    input  logic                        ser_data,
    input  logic                        ser_frame,
    input  logic                        load_en,
    output logic [7:0]                  byte_out,
    output logic                        new_byte,
    output logic                        programming,
    output logic [$clog2(MEM_DEPTH):0]  bytes_loaded,
    output logic                        overflow,
    output logic                        done
);

    import prog_byte_loader_pkg::*;

    localparam int CYC_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CYC_MAX + 1);
    localparam int BL_W    = $clog2(MEM_DEPTH) + 1;
    localparam int CNT_W   = $clog2(SER_BITS + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    state_t           state;
    logic [CW-1:0]    cyc;
    logic [1:0]       clk_sync;
    logic [1:0]       data_sync;
    logic [1:0]       frame_sync;
    logic             clk_prev;
    logic             ser_rise;
    logic [7:0]       shift_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic             deser_active;
    logic             byte_ready;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync   <= '0;
            data_sync  <= '0;
            frame_sync <= '0;
            clk_prev   <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], ser_clk};
            data_sync  <= {data_sync[0], ser_data};
            frame_sync <= {frame_sync[0], ser_frame};
            clk_prev   <= clk_sync[1];
        end
    end

    assign ser_rise     = clk_sync[1] && !clk_prev;
    assign deser_active = (state == S_IDLE) || (state == S_PULSE) || (state == S_GAP);
    // A full byte sits in shift_reg for one cycle with bit_cnt at SER_BITS; that is the push.
    assign byte_ready   = deser_active && (bit_cnt == CNT_W'(SER_BITS));
    assign fifo_pop     = (state == S_IDLE) && load_en && !fifo_empty;
    assign fifo_flush   = (state == S_OFF) && load_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (!deser_active || !frame_sync[1] || byte_ready) begin
            bit_cnt <= '0;
        end else if (ser_rise) begin
            shift_reg <= {shift_reg[6:0], data_sync[1]};
            bit_cnt   <= bit_cnt + CNT_W'(1);
        end
    end

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (byte_ready),
        .din   (shift_reg),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Pacing FSM; load_en is only re-examined at the end of a gap so a started byte always completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_OFF;
            cyc          <= '0;
            byte_out     <= '0;
            new_byte     <= 1'b0;
            programming  <= 1'b0;
            bytes_loaded <= '0;
            overflow     <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (byte_ready && fifo_full && !fifo_pop) overflow <= 1'b1;
            case (state)
                S_OFF: begin
                    if (load_en) begin
                        state        <= S_IDLE;
                        programming  <= 1'b1;
                        bytes_loaded <= '0;
                        overflow     <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (!load_en) begin
                        state       <= S_OFF;
                        programming <= 1'b0;
                    end else if (!fifo_empty) begin
                        byte_out <= fifo_head;
                        new_byte <= 1'b1;
                        cyc      <= '0;
                        state    <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (cyc == PULSE_LAST) begin
                        new_byte     <= 1'b0;
                        bytes_loaded <= bytes_loaded + BL_W'(1);
                        cyc          <= '0;
                        state        <= S_GAP;
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                S_GAP: begin
                    if (cyc == GAP_LAST) begin
                        cyc <= '0;
                        if (!load_en) begin
                            state       <= S_OFF;
                            programming <= 1'b0;
                        end else if (bytes_loaded == BL_W'(MEM_DEPTH)) begin
                            state       <= S_DONE;
                            programming <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                S_DONE: begin
                    if (!load_en) begin
                        state <= S_OFF;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_OFF;
                    new_byte    <= 1'b0;
                    programming <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule
